// File: rtl/conv_v2_pkg.sv
// conv_v2_pkg: width constants shared across the conv_v2 datapath, plus the
// accumulator output-width helper used by both the accumulator and its
// downstream requantisation stage.
package conv_v2_pkg;

    localparam int unsigned CONV_ACT_W  = 8;   // activation width
    localparam int unsigned CONV_BIAS_W = 12;  // signed bias width
    localparam int unsigned CONV_PROD_W = 8;   // product width feeding the accumulator
    localparam int unsigned CONV_ELEMS  = 9;   // elements summed per output (3x3)

    // Width needed to sum n_elem values of prod_w bits without overflow.
    function automatic int unsigned acc_out_w(input int unsigned prod_w,
                                              input int unsigned n_elem);
        return prod_w + int'($clog2(n_elem));
    endfunction

    localparam int unsigned CONV_ACC_W = acc_out_w(CONV_PROD_W, CONV_ELEMS);

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO.
// Ports:
//   iclk, irst_n      clock, async active-low reset (clears pointers/occupancy)
//   ipush, iwdata     write request and data; accepted when not full, or when
//                     full with a simultaneous pop
//   ipop              read request; ignored when empty
//   ordata            current head (zero while empty)
//   ofull, oempty     derived from the registered occupancy counter
module sync_fifo_fwft #(
    parameter int unsigned pWIDTH = 8,
    parameter int unsigned pDEPTH = 4
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              ipush,
    input  logic [pWIDTH-1:0] iwdata,
    input  logic              ipop,
    output logic [pWIDTH-1:0] ordata,
    output logic              ofull,
    output logic              oempty
);

    localparam int unsigned AW = $clog2(pDEPTH);
    localparam int unsigned CW = AW + 1;

    logic [pWIDTH-1:0] mem [pDEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push_c;
    logic              pop_c;

    assign ofull  = (count == CW'(pDEPTH));
    assign oempty = (count == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
    assign pop_c  = ipop & ~oempty;
    assign push_c = ipush & (~ofull | pop_c);

    // Pointer and occupancy registers
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_c) - CW'(pop_c);
        end
    end

    // Storage; contents are don't-care until written
    always_ff @(posedge iclk) begin
        if (push_c) mem[wr_ptr] <= iwdata;
    end

    assign ordata = oempty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/acc_requant_relu.sv
// acc_requant_relu: bias add, rounding right-shift, optional ReLU and
// saturation of accumulator sums, buffered in a FWFT FIFO onto a
// valid/ready stream. The accumulator cannot stall, so overflow drops results.
// Ports:
//   iclk, irst_n          clock, async active-low reset
//   idata, idata_en       accumulator sum and its one-cycle strobe
//   ibias, ishift         per-result signed bias and shift, sampled with idata_en
//   odata, ovalid, iready output stream (FIFO head / non-empty / consumer ready)
//   ofull                 FIFO full
//   odrop                 sticky flag: a result was lost to a full FIFO
//   osat_cnt              saturating count of clamped results
//   iclr_stats            synchronous clear of odrop and osat_cnt
module acc_requant_relu
    import conv_v2_pkg::*;
#(
    parameter int unsigned pDATA_IN_W  = CONV_ACC_W,
    parameter int unsigned pIN_SIGNED  = 0,
    parameter int unsigned pBIAS_W     = CONV_BIAS_W,
    parameter int unsigned pSHIFT_W    = 4,
    parameter int unsigned pDATA_OUT_W = CONV_ACT_W,
    parameter int unsigned pRELU       = 1,
    parameter int unsigned pFIFO_DEPTH = 4
) (
    input  logic                   iclk,
    input  logic                   irst_n,
    input  logic [pDATA_IN_W-1:0]  idata,
    input  logic                   idata_en,
    input  logic [pBIAS_W-1:0]     ibias,
    input  logic [pSHIFT_W-1:0]    ishift,
    output logic [pDATA_OUT_W-1:0] odata,
    output logic                   ovalid,
    input  logic                   iready,
    output logic                   ofull,
    output logic                   odrop,
    output logic [15:0]            osat_cnt,
    input  logic                   iclr_stats
);

    // Unsigned inputs need one extra bit to stay positive once made signed.
    localparam int unsigned IN_EXT_W = pDATA_IN_W + ((pIN_SIGNED != 0) ? 0 : 1);
    localparam int unsigned SUM_W    = ((IN_EXT_W > pBIAS_W) ? IN_EXT_W : pBIAS_W) + 1;
    localparam int unsigned RND_W    = SUM_W + 1;

    localparam logic signed [RND_W-1:0] MAX_V = (pRELU != 0)
        ? RND_W'((1 << pDATA_OUT_W) - 1)
        : RND_W'((1 << (pDATA_OUT_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] MIN_V = (pRELU != 0)
        ? '0
        : RND_W'(-(1 << (pDATA_OUT_W - 1)));

    // ---------------- S1: extend and add bias ----------------
    logic signed [SUM_W-1:0] in_ext_c;
    logic signed [SUM_W-1:0] bias_ext_c;
    logic signed [SUM_W-1:0] sum_c;

    always_comb begin
        if (pIN_SIGNED != 0) in_ext_c = SUM_W'(signed'(idata));
        else                 in_ext_c = SUM_W'(idata);
        bias_ext_c = SUM_W'(signed'(ibias));
        sum_c      = in_ext_c + bias_ext_c;
    end

    logic                    s1_vld;
    logic signed [SUM_W-1:0] s1_sum;
    logic [pSHIFT_W-1:0]     s1_shift;

    // S1 pipeline register
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            s1_vld   <= 1'b0;
            s1_sum   <= '0;
            s1_shift <= '0;
        end else begin
            s1_vld <= idata_en;
            if (idata_en) begin
                s1_sum   <= sum_c;
                s1_shift <= ishift;
            end
        end
    end

    // ---------------- S2: round, shift, ReLU, clamp ----------------
    logic signed [RND_W-1:0]  rnd_c;
    logic signed [RND_W-1:0]  rounded_c;
    logic signed [RND_W-1:0]  shifted_c;
    logic [pDATA_OUT_W-1:0]   res_c;
    logic                     sat_c;

    always_comb begin
        rnd_c = '0;
        if (s1_shift != '0) rnd_c = RND_W'(1) << (s1_shift - pSHIFT_W'(1));
        rounded_c = RND_W'(s1_sum) + rnd_c;

        // Shifting the whole sum away leaves only its sign.
        if (32'(s1_shift) >= SUM_W) shifted_c = {RND_W{s1_sum[SUM_W-1]}};
        else                        shifted_c = rounded_c >>> s1_shift;

        res_c = shifted_c[pDATA_OUT_W-1:0];
        sat_c = 1'b0;
        if ((pRELU != 0) && shifted_c[RND_W-1]) begin
            res_c = '0;
        end else if (shifted_c > MAX_V) begin
            res_c = MAX_V[pDATA_OUT_W-1:0];
            sat_c = 1'b1;
        end else if ((pRELU == 0) && (shifted_c < MIN_V)) begin
            res_c = MIN_V[pDATA_OUT_W-1:0];
            sat_c = 1'b1;
        end
    end

    logic                   s2_vld;
    logic [pDATA_OUT_W-1:0] s2_data;

    // S2 pipeline register
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            s2_vld  <= 1'b0;
            s2_data <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) s2_data <= res_c;
        end
    end

    // ---------------- Output buffer ----------------
    logic fifo_empty;
    logic pop_c;

    assign ovalid = ~fifo_empty;
    assign pop_c  = ovalid & iready;

    sync_fifo_fwft #(
        .pWIDTH (pDATA_OUT_W),
        .pDEPTH (pFIFO_DEPTH)
    ) u_out_fifo (
        .iclk   (iclk),
        .irst_n (irst_n),
        .ipush  (s2_vld),
        .iwdata (s2_data),
        .ipop   (pop_c),
        .ordata (odata),
        .ofull  (ofull),
        .oempty (fifo_empty)
    );

    // Drop flag and clamp counter; a clear in the same cycle takes priority
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            odrop    <= 1'b0;
            osat_cnt <= '0;
        end else if (iclr_stats) begin
            odrop    <= 1'b0;
            osat_cnt <= '0;
        end else begin
            if (s2_vld && ofull && !pop_c) odrop <= 1'b1;
            if (s1_vld && sat_c && (osat_cnt != 16'hFFFF)) osat_cnt <= osat_cnt + 16'd1;
        end
    end

endmodule
